// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: data width, NOP encoding, fetch FSM states
// and the {pc, inst} entry carried by the fetch FIFO.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  // IDLE: nothing in flight | REQ: waiting for grant | RESP: waiting for rvalid | HALT: fault trap
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer with a registered head; the head register keeps the last
// popped entry when the buffer drains so the consumer's pc output holds steady.
module fetch_fifo
  import rv32_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_head;
  fetch_entry_t r_tail;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 2'd0;
      r_head  <= {{XLEN{1'b0}}, INST_NOP};
      r_tail  <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_push_data;
          else                 r_tail <= i_push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_push_data;
          end else begin
            r_head <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, single-outstanding imem handshake, 2-entry output buffer.
// FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise fetch_fault and park in HALT.
module instruction_fetch
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_fetch_fault
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] r_rsp_pc;
  logic [XLEN-1:0] w_rsp_pc_next;
  logic            r_discard;
  logic            w_discard_next;
  logic            w_misalign;
  logic [XLEN-1:0] w_target;
  logic            w_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_busy_next;
  logic            w_can_issue;
  logic            w_req_early;
  logic            w_grant;
  logic [1:0]      w_count;
  logic [2:0]      w_occ_next;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;

  assign w_misalign = i_redirect && (i_redirect_pc[1:0] != 2'b00);
  assign w_target   = i_redirect_pc;

  always_ff @(posedge i_clk) begin
    if (i_reset)         r_fault <= 1'b0;
    else if (i_redirect) r_fault <= w_misalign;
  end

  assign o_fetch_fault = r_fault;
`else
  assign w_misalign    = 1'b0;
  assign w_target      = i_redirect_pc & ~(XLEN'(3));
  assign o_fetch_fault = 1'b0;
`endif

  assign w_valid     = (w_count != 2'd0);
  assign w_pop       = w_valid && i_inst_ready;
  assign w_push      = (r_state == ST_RESP) && i_imem_rvalid && !r_discard && !i_redirect;
  assign w_push_data = {r_rsp_pc, i_imem_rdata};
  assign w_occ_next  = i_redirect ? 3'd0
                     : ({1'b0, w_count} + {2'b00, w_push} - {2'b00, w_pop});

  // Whether a response is still owed to us after this edge, before any new issue.
  always_comb begin
    w_busy_next = 1'b0;
    case (r_state)
      ST_REQ:  w_busy_next = i_imem_gnt;
      ST_RESP: w_busy_next = !i_imem_rvalid;
      default: w_busy_next = r_discard && !i_imem_rvalid;
    endcase
  end

  assign w_can_issue = !w_busy_next && (w_occ_next <= 3'd1);
  // Back-to-back issue in the response cycle is what allows one instruction per cycle.
  assign w_req_early = (r_state == ST_RESP) && i_imem_rvalid && !i_redirect && w_can_issue;
  assign o_imem_req  = (r_state == ST_REQ) || w_req_early;
  assign o_imem_addr = r_pc;
  assign w_grant     = o_imem_req && i_imem_gnt;

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_rsp_pc_next  = r_rsp_pc;
    w_discard_next = i_imem_rvalid ? 1'b0 : r_discard;
    if (i_redirect) begin
      w_discard_next = w_busy_next;
      if (w_misalign) begin
        w_state_next = ST_HALT;
      end else begin
        w_pc_next    = w_target;
        w_state_next = w_busy_next ? ST_RESP : ST_REQ;
      end
    end else begin
      if (w_grant) begin
        w_pc_next     = r_pc + XLEN'(4);
        w_rsp_pc_next = r_pc;
      end
      case (r_state)
        ST_IDLE: if (w_can_issue) w_state_next = ST_REQ;
        ST_REQ:  if (i_imem_gnt) w_state_next = ST_RESP;
        ST_RESP: begin
          if (i_imem_rvalid) begin
            if (w_req_early) w_state_next = i_imem_gnt ? ST_RESP : ST_REQ;
            else             w_state_next = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_rsp_pc  <= RESET_PC;
      r_discard <= (r_state == ST_RESP);
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_rsp_pc  <= w_rsp_pc_next;
      r_discard <= w_discard_next;
    end
  end

  fetch_fifo u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_redirect),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign o_inst_valid = w_valid;
  assign o_inst       = w_valid ? w_head.inst : INST_NOP;
  assign o_inst_pc    = w_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch against a memory model returning addr^A5A5A5A5.
// Cycle 0 is the first cycle with reset low; inputs change 1ns after posedge, checks at negedge.
`timescale 1ns/1ps
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  logic        gnt_block = 1'b0;
  int unsigned rsp_lat = 0;
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = 32'h0;
  int unsigned m_lat = 0;

  int n_vec  = 0;
  int n_fail = 0;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  always #5 clk = ~clk;

  assign imem_gnt    = imem_req && !gnt_block;
  assign imem_rvalid = m_pend && (m_lat == 0);
  assign imem_rdata  = imem_rvalid ? (m_addr ^ KEY) : 32'h0;

  always_ff @(posedge clk) begin
    if (imem_gnt) begin
      m_pend <= 1'b1;
      m_addr <= imem_addr;
      m_lat  <= rsp_lat;
    end else if (imem_rvalid) begin
      m_pend <= 1'b0;
    end else if (m_pend) begin
      m_lat <= m_lat - 1;
    end
  end

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_inst_valid  (inst_valid),
    .i_inst_ready  (inst_ready),
    .o_inst        (inst),
    .o_inst_pc     (inst_pc),
    .o_fetch_fault (fetch_fault)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    inst_ready  = 1'b1;
    gnt_block   = 1'b0;
    rsp_lat     = 0;
    repeat (3) cyc();
    reset = 1'b0;
  endtask

  initial begin
    // zero-wait streaming from RESET_PC
    do_reset();
    settle();
    chk("rst_req",     {31'b0, imem_req},    32'h0);
    chk("rst_addr",    imem_addr,            32'h100);
    chk("rst_valid",   {31'b0, inst_valid},  32'h0);
    chk("rst_inst",    inst,                 32'h0000_0013);
    chk("rst_inst_pc", inst_pc,              32'h0);
    chk("rst_fault",   {31'b0, fetch_fault}, 32'h0);
    cyc(); settle();
    chk("c1_req",  {31'b0, imem_req}, 32'h1);
    chk("c1_addr", imem_addr,         32'h100);
    cyc(); cyc(); settle();
    chk("s_valid0", {31'b0, inst_valid}, 32'h1);
    chk("s_pc0",    inst_pc,             32'h100);
    chk("s_inst0",  inst,                32'hA5A5_A4A5);
    for (int i = 1; i < 4; i++) begin
      cyc(); settle();
      chk("s_valid", {31'b0, inst_valid}, 32'h1);
      chk("s_pc",    inst_pc,             32'h100 + 32'(4 * i));
      chk("s_inst",  inst,                (32'h100 + 32'(4 * i)) ^ KEY);
    end

    // grant withheld for three cycles on the 0x104 request
    do_reset();
    cyc(); cyc();
    gnt_block = 1'b1;
    settle();
    chk("g2_req",  {31'b0, imem_req}, 32'h1);
    chk("g2_addr", imem_addr,         32'h104);
    cyc(); settle();
    chk("g3_req",  {31'b0, imem_req}, 32'h1);
    chk("g3_addr", imem_addr,         32'h104);
    chk("g3_pc",   inst_pc,           32'h100);
    cyc(); settle();
    chk("g4_req",   {31'b0, imem_req},   32'h1);
    chk("g4_addr",  imem_addr,           32'h104);
    chk("g4_valid", {31'b0, inst_valid}, 32'h0);
    cyc();
    gnt_block = 1'b0;
    settle();
    chk("g5_addr", imem_addr, 32'h104);
    cyc(); settle();
    chk("g6_valid", {31'b0, inst_valid}, 32'h0);
    chk("g6_addr",  imem_addr,           32'h108);
    cyc(); settle();
    chk("g7_valid", {31'b0, inst_valid}, 32'h1);
    chk("g7_pc",    inst_pc,             32'h104);
    cyc(); settle();
    chk("g8_pc", inst_pc, 32'h108);

    // consumer stalled six cycles: buffer fills, requests stop
    do_reset();
    inst_ready = 1'b0;
    cyc(); cyc(); cyc(); settle();
    chk("b3_req", {31'b0, imem_req}, 32'h0);
    cyc(); settle();
    chk("b4_req", {31'b0, imem_req}, 32'h0);
    cyc(); settle();
    chk("b5_req",   {31'b0, imem_req},   32'h0);
    chk("b5_valid", {31'b0, inst_valid}, 32'h1);
    chk("b5_pc",    inst_pc,             32'h100);
    cyc();
    inst_ready = 1'b1;
    settle();
    chk("b6_pc",  inst_pc,           32'h100);
    chk("b6_req", {31'b0, imem_req}, 32'h0);
    cyc(); settle();
    chk("b7_pc",   inst_pc,           32'h104);
    chk("b7_req",  {31'b0, imem_req}, 32'h1);
    chk("b7_addr", imem_addr,         32'h108);
    cyc(); settle();
    chk("b8_valid", {31'b0, inst_valid}, 32'h0);
    cyc(); settle();
    chk("b9_valid", {31'b0, inst_valid}, 32'h1);
    chk("b9_pc",    inst_pc,             32'h108);

    // redirect while waiting for a response that arrives next cycle
    do_reset();
    rsp_lat = 1;
    cyc(); cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    settle();
    chk("r2_valid", {31'b0, inst_valid}, 32'h0);
    cyc();
    redirect = 1'b0;
    settle();
    chk("r3_req",   {31'b0, imem_req},   32'h1);
    chk("r3_addr",  imem_addr,           32'h200);
    chk("r3_valid", {31'b0, inst_valid}, 32'h0);
    cyc(); settle();
    chk("r4_valid", {31'b0, inst_valid}, 32'h0);
    cyc(); settle();
    chk("r5_valid", {31'b0, inst_valid}, 32'h0);
    cyc(); settle();
    chk("r6_valid", {31'b0, inst_valid}, 32'h1);
    chk("r6_pc",    inst_pc,             32'h200);
    chk("r6_inst",  inst,                32'hA5A5_A7A5);
    rsp_lat = 0;

    // redirect coinciding with rvalid while one entry is buffered
    do_reset();
    inst_ready = 1'b0;
    cyc(); cyc(); cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    settle();
    chk("x3_valid", {31'b0, inst_valid}, 32'h1);
    chk("x3_pc",    inst_pc,             32'h100);
    chk("x3_req",   {31'b0, imem_req},   32'h0);
    cyc();
    redirect   = 1'b0;
    inst_ready = 1'b1;
    settle();
    chk("x4_valid", {31'b0, inst_valid}, 32'h0);
    chk("x4_req",   {31'b0, imem_req},   32'h1);
    chk("x4_addr",  imem_addr,           32'h200);
    cyc(); cyc(); settle();
    chk("x6_valid", {31'b0, inst_valid}, 32'h1);
    chk("x6_pc",    inst_pc,             32'h200);

    // misaligned redirect target
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h202;
    cyc();
    redirect = 1'b0;
    settle();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("m1_fault", {31'b0, fetch_fault}, 32'h1);
    chk("m1_req",   {31'b0, imem_req},    32'h0);
    cyc(); settle();
    chk("m2_fault", {31'b0, fetch_fault}, 32'h1);
    chk("m2_req",   {31'b0, imem_req},    32'h0);
    chk("m2_valid", {31'b0, inst_valid},  32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    cyc();
    redirect = 1'b0;
    settle();
    chk("m3_fault", {31'b0, fetch_fault}, 32'h0);
    chk("m3_req",   {31'b0, imem_req},    32'h1);
    chk("m3_addr",  imem_addr,            32'h300);
    cyc(); cyc(); settle();
    chk("m5_valid", {31'b0, inst_valid}, 32'h1);
    chk("m5_pc",    inst_pc,             32'h300);
`else
    chk("m1_fault", {31'b0, fetch_fault}, 32'h0);
    chk("m1_req",   {31'b0, imem_req},    32'h1);
    chk("m1_addr",  imem_addr,            32'h200);
    cyc(); cyc(); settle();
    chk("m3_valid", {31'b0, inst_valid}, 32'h1);
    chk("m3_pc",    inst_pc,             32'h200);
`endif

    // pc wraps from the top of the address space to zero
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    settle();
    chk("w1_addr", imem_addr,         32'hFFFF_FFFC);
    chk("w1_req",  {31'b0, imem_req}, 32'h1);
    cyc(); settle();
    chk("w2_addr", imem_addr,         32'h0);
    chk("w2_req",  {31'b0, imem_req}, 32'h1);
    cyc(); settle();
    chk("w3_pc",   inst_pc, 32'hFFFF_FFFC);
    chk("w3_inst", inst,    32'h5A5A_5A59);
    cyc(); settle();
    chk("w4_pc",   inst_pc, 32'h0);
    chk("w4_inst", inst,    32'hA5A5_A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Sequential front-end stage feeding the instruction decoder. Keeps the program counter and issues word reads to instruction memory over a request/grant/response handshake, with at most one request outstanding. Returned words are buffered in a 2-entry FIFO and presented to the decoder as `inst`/`inst_pc` with a valid/ready handshake. Redirects from jump control flush the pipe and restart fetch at a new target.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `imem_req` output 1: read request to instruction memory.
- `imem_addr` output 32: word address of the request (bits[1:0] always 0).
- `imem_gnt` input 1: memory accepts the request this cycle.
- `imem_rvalid` input 1: read data valid for the oldest granted request.
- `imem_rdata` input 32: instruction word.
- `redirect` input 1: jump or branch taken; restart fetch.
- `redirect_pc` input 32: new fetch target.
- `inst_valid` output 1: `inst`/`inst_pc` hold a valid instruction.
- `inst_ready` input 1: decoder stage consumes the instruction this cycle.
- `inst` output 32: instruction word to the decoder.
- `inst_pc` output 32: address of `inst`.
- `fetch_fault` output 1: misaligned redirect target. Present only with the configuration macro; otherwise tied to 0.

## Operation
- **Reset values:**
  - `pc`=RESET_PC, FSM=IDLE, FIFO empty, discard=0.
  - `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst`=32'h0000_0013 (NOP), `inst_pc`=0, `fetch_fault`=0.
- **FSM states:**
  - IDLE: no request in flight.
  - REQ: `imem_req`=1, waiting for `imem_gnt`.
  - RESP: request granted, waiting for `imem_rvalid`.
- **Issue rule:** a new request is raised (IDLE→REQ, or RESP→REQ) when both hold:
  - no request will be outstanding at the end of this cycle (IDLE, or RESP with `imem_rvalid`=1);
  - FIFO occupancy after this cycle's push/pop is ≤1.
- **REQ→RESP:** on `imem_gnt`. `pc` increments by 4 at grant. `imem_req`/`imem_addr` stay stable until grant unless a redirect occurs.
- **RESP:** on `imem_rvalid`, push {`imem_rdata`, address} into the FIFO, unless discard=1. In that case the word is dropped and discard clears.
- **FIFO head drives the outputs.**
  - `inst_valid`=!empty; a pop occurs when `inst_valid`&&`inst_ready`.
  - When empty, `inst`=NOP and `inst_pc` holds its last value.
- **Redirect (highest priority, any state):**
  - FIFO flushed, `pc`=`redirect_pc`.
  - In RESP without `imem_rvalid` this cycle: discard=1.
  - A response arriving in the redirect cycle is dropped.
  - In REQ: `imem_addr` switches to the new target next cycle with `imem_req` kept high. Memory must tolerate address change on an ungranted request.
  - A pop in the redirect cycle is still counted as consumed.
- **Simultaneous events:**
  - Push+pop in the same cycle keeps occupancy.
  - FIFO full (2) blocks issue; never overflows.
- **`pc` wrap:** 32'hFFFF_FFFC + 4 → 0, no flag.
- **Reset mid-operation:** an outstanding response after reset is ignored via discard=1. Reset forces discard=1 if the FSM was in RESP; otherwise the reset values above apply.

## Timing
- Latency redirect→request: `imem_req` with the new address in cycle +1.
- Zero-wait memory (grant same cycle, rvalid next cycle) sustains 1 instruction/cycle once primed while `inst_ready`=1.
- First instruction after reset:
  - request in cycle 1 after `reset` deasserts;
  - `inst_valid` in the cycle after `imem_rvalid`, since the FIFO output is registered.
- `inst_ready` low for N cycles: the FIFO fills to 2 and `imem_req` stays low until a pop.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - `redirect` with `redirect_pc[1:0]`≠0 sets `fetch_fault`=1 (held) and enters state HALT: no requests, FIFO empty.
  - Leave HALT only on an aligned redirect or reset; `fetch_fault` clears at that edge.
- Undefined: `redirect_pc[1:0]` is forced to 0, no HALT state, `fetch_fault` constant 0.

## Structure
- Shared package `rv32_pkg`:
  - `XLEN`=32, `INST_NOP`=32'h0000_0013;
  - FSM state encodings (IDLE, REQ, RESP, HALT).
- Sub-module `fetch_fifo`:
  - 2-entry, 64-bit payload {pc, inst};
  - push/pop/flush ports, count output, registered head.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory returning addr^0xA5A5A5A5, `inst_ready`=1 → `inst_pc` 0x100,0x104,0x108… on consecutive cycles, correct words.
- `imem_gnt` delayed 3 cycles → `imem_addr` stable at 0x104 with `imem_req`=1 throughout, no duplicate fetch.
- `inst_ready`=0 for 6 cycles → FIFO holds 2 entries, `imem_req`=0, no lost or duplicated PCs after release.
- Redirect to 0x200 while in RESP, rvalid arrives next cycle → that word is dropped; next `inst_pc`=0x200.
- Redirect and `imem_rvalid` in the same cycle with FIFO holding 1 entry → both dropped, `inst_valid`=0 next cycle, request 0x200 issued.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x202 → `fetch_fault`=1, `imem_req`=0; redirect to 0x300 → fault clears, fetch resumes at 0x300.
